// File: rtl/binary_to_gray_counter.sv
// Binary up/down counter with a registered Gray-code mirror and optional wrap pulse.
//
// Ports:
//   clk       - sole clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset (bin = gray = wrap = 0)
//   en        - count enable, one step per cycle while high
//   up_dn     - direction, 1 = increment, 0 = decrement
//   load      - synchronous load strobe (beats en)
//   load_bin  - binary value captured on load
//   bin       - registered binary count
//   gray      - registered Gray code of bin (same cycle as bin)
//   wrap      - registered one-cycle pulse on an up or down wrap
//
// Configuration macro: GRAY_CNT_WRAP_PULSE_EN
//   defined   - wrap pulses on the step that wraps all-ones->0 or 0->all-ones
//   undefined - wrap is tied to 0 and no wrap-detect logic exists
module binary_to_gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  // Next binary value: load beats count, count beats hold.
  always_comb begin
    bin_d = bin_q;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) bin_d = bin_q + WIDTH'(1);
      else       bin_d = bin_q - WIDTH'(1);
    end
  end

  // Gray is derived from the next binary value so both registers update together.
  always_comb begin
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Binary and Gray state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= ZERO;
      gray_q <= ZERO;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;

`ifdef GRAY_CNT_WRAP_PULSE_EN
  logic wrap_q, wrap_d;

  // Only a counting step can wrap; load and hold always clear the pulse.
  always_comb begin
    wrap_d = 1'b0;
    if (!load && en) begin
      if (up_dn) wrap_d = (bin_q == ALL_ONES);
      else       wrap_d = (bin_q == ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_gray_counter.sv
module tb_binary_to_gray_counter;

  localparam int unsigned WIDTH = 4;
  localparam int MOD  = 1 << WIDTH;
  localparam int MAXV = MOD - 1;
`ifdef GRAY_CNT_WRAP_PULSE_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  int n_checks = 0;
  int n_fail   = 0;

  binary_to_gray_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: integer count with modular arithmetic.
  int m_bin   = 0;
  bit m_wrap  = 1'b0;
  bit m_valid = 1'b0;
  bit m_step  = 1'b0;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk) begin
    m_step = 1'b0;
    if (!rst_n) begin
      m_bin   = 0;
      m_wrap  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (load) begin
        m_bin  = int'(load_bin);
        m_wrap = 1'b0;
      end else if (en) begin
        m_step = 1'b1;
        if (up_dn) begin
          m_wrap = WRAP_ON && (m_bin == MAXV);
          m_bin  = (m_bin + 1) % MOD;
        end else begin
          m_wrap = WRAP_ON && (m_bin == 0);
          m_bin  = (m_bin + MOD - 1) % MOD;
        end
      end else begin
        m_wrap = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic [WIDTH-1:0] last_gray;
  bit               have_last = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_bin",  int'(bin),  m_bin);
      chk("model_gray", int'(gray), to_gray(m_bin));
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("gray_of_bin", int'(gray), int'(bin ^ (bin >> 1)));
      if (m_step && have_last)
        chk("one_bit_step", $countones(gray ^ last_gray), 1);
      last_gray = gray;
      have_last = 1'b1;
    end
  end

  // Apply one cycle of inputs; return 1 time unit after the edge.
  task automatic cyc(input bit r, input bit ld, input int lb, input bit e, input bit ud);
    rst_n    = r;
    load     = ld;
    load_bin = WIDTH'(lb);
    en       = e;
    up_dn    = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int b, input int g, input bit w);
    chk({name, "_bin"},  int'(bin),  b);
    chk({name, "_gray"}, int'(gray), g);
    chk({name, "_wrap"}, int'(wrap), int'(w));
  endtask

  int gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
    @(posedge clk); #1;

    // Full up count with wrap.
    cyc(0, 0, 0, 1, 1);
    expect_out("reset", 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 1, 1);
      chk("upseq_gray", int'(gray), gseq[k % 16]);
      chk("upseq_wrap", int'(wrap), (k == 16) ? int'(WRAP_ON) : 0);
    end
    cyc(1, 0, 0, 0, 1);
    expect_out("post_wrap_hold", 0, 0, 0);

    // Load zero, then down wrap and one more down step.
    cyc(1, 1, 4'b0000, 0, 0);
    expect_out("load0", 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    expect_out("down_wrap", 4'b1111, 4'b1000, WRAP_ON);
    cyc(1, 0, 0, 1, 0);
    expect_out("down_next", 4'b1110, 4'b1001, 0);

    // Load beats enable.
    cyc(1, 1, 4'b1010, 1, 1);
    expect_out("load_over_en", 4'b1010, 4'b1111, 0);

    // Load at all-ones with en up must not wrap.
    cyc(1, 1, 4'b1111, 0, 1);
    cyc(1, 1, 4'b0011, 1, 1);
    expect_out("load_no_wrap", 4'b0011, 4'b0010, 0);

    // Count to 6, hold 3 cycles, reverse direction without a dead cycle.
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 1, 1);
    expect_out("at6", 4'b0110, 4'b0101, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 1);
      expect_out("hold", 4'b0110, 4'b0101, 0);
    end
    cyc(1, 0, 0, 1, 0);
    expect_out("reverse", 4'b0101, 4'b0111, 0);

    // Reset at all-ones with en high: no wrap, restart from zero.
    cyc(1, 1, 4'b1111, 0, 1);
    expect_out("load_max", 4'b1111, 4'b1000, 0);
    cyc(0, 1, 4'b0101, 1, 1);
    expect_out("reset_over_en", 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    expect_out("after_reset", 1, 1, 0);

    // Mixed directed run for the per-cycle model compare.
    for (int k = 0; k < 40; k++)
      cyc(1, (k % 13) == 12, k * 7, (k % 5) != 3, (k / 9) % 2 == 0);

    cyc(1, 0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
